mod_mul_il_rdx: RTL and testbench



---
 rtl/mod_mul_il_pkg.sv | 26 ++
 rtl/mod_mul_il_tab.sv | 98 +++++++++
 rtl/mod_mul_il_rdx.sv | 174 +++++++++++++++++
 tb/tb_mod_mul_il_rdx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mod_mul_il_pkg.sv
// Shared types and sizing helpers for the interleaved radix-2^PBITS modular multiplier.
package mod_mul_il_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Number of PBITS-wide digits needed to cover an NBITS operand.
  function automatic int unsigned num_digits(input int unsigned nbits, input int unsigned pbits);
    return (nbits + pbits - 1) / pbits;
  endfunction

  // Accumulator width: (y<<PBITS) + bt fits in NBITS+PBITS+1 bits.
  function automatic int unsigned acc_width(input int unsigned nbits, input int unsigned pbits);
    return nbits + pbits + 1;
  endfunction

  // Entries per multiple table (2^PBITS).
  function automatic int unsigned tab_entries(input int unsigned pbits);
    return 32'd1 << pbits;
  endfunction

endpackage

// File: rtl/mod_mul_il_tab.sv
// Multiple tables mt[j]=j*m (j=1..2^PBITS) and bt[k]=k*b mod m (k=0..2^PBITS-1),
// built one entry per cycle after start_c, with a validity flag for reuse.
module mod_mul_il_tab
  import mod_mul_il_pkg::*;
#(
  parameter int unsigned NBITS = 4096,
  parameter int unsigned PBITS = 2
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start_c,
  input  logic [NBITS-1:0]                             b,
  input  logic [NBITS-1:0]                             m,
  input  logic [PBITS-1:0]                             digit,
  output logic [NBITS-1:0]                             bt_sel_c,
  output logic [tab_entries(PBITS)*acc_width(NBITS, PBITS)-1:0] mt_flat,
  output logic                                         tables_valid,
  output logic                                         pre_last_c
);

  localparam int unsigned ACC_W = acc_width(NBITS, PBITS);
  localparam int unsigned TAB_N = tab_entries(PBITS);

  logic [ACC_W-1:0] mt_q [TAB_N];
  logic [ACC_W-1:0] mt_d [TAB_N];
  logic [NBITS-1:0] bt_q [TAB_N];
  logic [NBITS-1:0] bt_d [TAB_N];
  logic [ACC_W-1:0] mt_run_q, mt_run_d;
  logic [NBITS-1:0] bt_run_q, bt_run_d;
  logic [PBITS-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             tv_q, tv_d;
  logic [NBITS:0]   bt_sum_c;

  // Step cnt writes mt[cnt+1] and bt[cnt]; running sums carry the previous entry.
  always_comb begin
    mt_d     = mt_q;
    bt_d     = bt_q;
    mt_run_d = mt_run_q;
    bt_run_d = bt_run_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    tv_d     = tv_q;
    bt_sum_c = {1'b0, bt_run_q} + {1'b0, b};
    if (start_c) begin
      run_d    = 1'b1;
      cnt_d    = '0;
      mt_run_d = '0;
      bt_run_d = '0;
      tv_d     = 1'b0;
    end else if (run_q) begin
      mt_d[cnt_q] = mt_run_q + ACC_W'(m);
      mt_run_d    = mt_run_q + ACC_W'(m);
      bt_d[cnt_q] = bt_run_q;
      if (bt_sum_c >= {1'b0, m}) begin
        bt_run_d = NBITS'(bt_sum_c - {1'b0, m});
      end else begin
        bt_run_d = NBITS'(bt_sum_c);
      end
      cnt_d = cnt_q + PBITS'(1);
      if (cnt_q == PBITS'(TAB_N - 1)) begin
        run_d = 1'b0;
        tv_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < TAB_N; j++) begin
        mt_q[j] <= '0;
        bt_q[j] <= '0;
      end
      mt_run_q <= '0;
      bt_run_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      tv_q     <= 1'b0;
    end else begin
      mt_q     <= mt_d;
      bt_q     <= bt_d;
      mt_run_q <= mt_run_d;
      bt_run_q <= bt_run_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      tv_q     <= tv_d;
    end
  end

  for (genvar g = 0; g < TAB_N; g++) begin : g_mt
    assign mt_flat[g*ACC_W +: ACC_W] = mt_q[g];
  end

  assign bt_sel_c     = bt_q[digit];
  assign tables_valid = tv_q;
  assign pre_last_c   = run_q && (cnt_q == PBITS'(TAB_N - 1));

endmodule

// File: rtl/mod_mul_il_rdx.sv
// Radix-2^PBITS interleaved modular multiplier y = a*b mod m with valid/ready
// handshakes and optional reuse of the b/m multiple tables.
module mod_mul_il_rdx
  import mod_mul_il_pkg::*;
#(
  parameter int unsigned NBITS = 4096,
  parameter int unsigned PBITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             reuse_mb,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] y,
  output logic             err,
  output logic             busy
);

  localparam int unsigned D     = num_digits(NBITS, PBITS);
  localparam int unsigned DP    = D * PBITS;
  localparam int unsigned ACC_W = acc_width(NBITS, PBITS);
  localparam int unsigned TAB_N = tab_entries(PBITS);
  localparam int unsigned DCW   = $clog2(D + 1);

  state_e           state_q, state_d;
  logic [DP-1:0]    a_sh_q, a_sh_d;
  logic [NBITS-1:0] b_q, b_d, m_q, m_d;
  logic [NBITS-1:0] y_acc_q, y_acc_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic             err_pend_q, err_pend_d;
  logic [NBITS-1:0] y_q, y_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic                   accept_c, chk_err_c, pre_start_c;
  logic [PBITS-1:0]       digit_c;
  logic [NBITS-1:0]       bt_sel_c;
  logic [TAB_N*ACC_W-1:0] mt_flat;
  logic                   tables_valid, pre_last_c;
  logic [ACC_W-1:0]       acc_c, sub_c, red_c;

  assign accept_c    = in_valid && in_ready_q;
  assign chk_err_c   = (m == '0) || (a >= m) || (b >= m);
  assign pre_start_c = accept_c && !chk_err_c && !(reuse_mb && tables_valid);
  assign digit_c     = a_sh_q[DP-1 -: PBITS];

  mod_mul_il_tab #(.NBITS(NBITS), .PBITS(PBITS)) u_tab (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_c      (pre_start_c),
    .b            (b_q),
    .m            (m_q),
    .digit        (digit_c),
    .bt_sel_c     (bt_sel_c),
    .mt_flat      (mt_flat),
    .tables_valid (tables_valid),
    .pre_last_c   (pre_last_c)
  );

  // One digit step: shift in the digit's b-multiple, then drop the largest j*m not above it.
  always_comb begin
    acc_c = (ACC_W'(y_acc_q) << PBITS) + ACC_W'(bt_sel_c);
    sub_c = '0;
    for (int unsigned j = 0; j < TAB_N; j++) begin
      if (acc_c >= mt_flat[j*ACC_W +: ACC_W]) begin
        sub_c = mt_flat[j*ACC_W +: ACC_W];
      end
    end
    red_c = acc_c - sub_c;
  end

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_d        = b_q;
    m_d        = m_q;
    y_acc_d    = y_acc_q;
    dcnt_d     = dcnt_q;
    err_pend_d = err_pend_q;
    y_d        = y_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          a_sh_d     = DP'(a);
          b_d        = b;
          m_d        = m;
          y_acc_d    = '0;
          dcnt_d     = '0;
          err_pend_d = chk_err_c;
          if (chk_err_c || (reuse_mb && tables_valid)) begin
            state_d = RUN;
          end else begin
            state_d = PRE;
          end
        end
      end
      PRE: begin
        if (pre_last_c) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (err_pend_q) begin
          state_d = DONE;
          y_d     = '0;
          err_d   = 1'b1;
        end else begin
          y_acc_d = NBITS'(red_c);
          a_sh_d  = a_sh_q << PBITS;
          dcnt_d  = dcnt_q + DCW'(1);
          if (dcnt_q == DCW'(D - 1)) begin
            state_d = DONE;
            y_d     = NBITS'(red_c);
            err_d   = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_q         <= '0;
      m_q         <= '0;
      y_acc_q     <= '0;
      dcnt_q      <= '0;
      err_pend_q  <= 1'b0;
      y_q         <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_q         <= b_d;
      m_q         <= m_d;
      y_acc_q     <= y_acc_d;
      dcnt_q      <= dcnt_d;
      err_pend_q  <= err_pend_d;
      y_q         <= y_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mod_mul_il_rdx.sv
// Bench for mod_mul_il_rdx: directed vectors on an 8-bit/radix-4 instance and
// directed plus random traffic on four 10-bit instances (PBITS=1..4).
module tb_mod_mul_il_rdx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 8-bit, radix-4 instance
  logic       in_valid, in_ready, reuse_mb, out_valid, out_ready, err, busy;
  logic [7:0] a, b, m, y;

  mod_mul_il_rdx #(.NBITS(8), .PBITS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .reuse_mb(reuse_mb), .a(a), .b(b), .m(m), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .err(err), .busy(busy)
  );

  // 10-bit instances sharing one input bus, PBITS = g+1
  logic       g_in_valid, g_reuse, g_out_ready;
  logic [9:0] g_a, g_b, g_m;
  logic       g_in_ready [4];
  logic       g_out_valid [4];
  logic       g_err [4];
  logic       g_busy [4];
  logic [9:0] g_y [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mod_mul_il_rdx #(.NBITS(10), .PBITS(g + 1)) u_g (
      .clk(clk), .rst_n(rst_n), .in_valid(g_in_valid), .in_ready(g_in_ready[g]),
      .reuse_mb(g_reuse), .a(g_a), .b(g_b), .m(g_m), .out_valid(g_out_valid[g]),
      .out_ready(g_out_ready), .y(g_y[g]), .err(g_err[g]), .busy(g_busy[g])
    );
  end

  typedef struct {
    logic [7:0] a, b, m;
    logic       reuse;
    logic [7:0] ey;
    logic       eerr;
    int         elat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input int p, input logic reuse);
    int d;
    d = (10 + p - 1) / p;
    return reuse ? d : (1 << p) + d;
  endfunction

  task automatic op8(input logic [7:0] ia, ib, im, input logic ir,
                     output logic [7:0] oy, output logic oe, output int olat);
    @(negedge clk);
    chk("in_ready_before_accept", longint'(in_ready), 1);
    a = ia; b = ib; m = im; reuse_mb = ir; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    olat = 0;
    while (!out_valid && olat < 100) begin
      @(posedge clk);
      #1 olat++;
    end
    oy = y;
    oe = err;
  endtask

  task automatic take8();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("in_ready_after_take", longint'(in_ready), 1);
    chk("out_valid_after_take", longint'(out_valid), 0);
  endtask

  task automatic opg(input logic [9:0] ia, ib, im, input logic ir);
    int     glat [4];
    int     cyc;
    logic   all_done;
    logic [9:0] ey;
    ey = 10'((64'(ia) * 64'(ib)) % 64'(im));
    @(negedge clk);
    g_a = ia; g_b = ib; g_m = im; g_reuse = ir; g_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) glat[k] = -1;
    @(posedge clk);
    #1 g_in_valid = 1'b0;
    cyc = 0;
    all_done = 1'b0;
    while (!all_done && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
      all_done = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (g_out_valid[k] && glat[k] < 0) glat[k] = cyc;
        if (glat[k] < 0) all_done = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("g%0d_y", k + 1), longint'(g_y[k]), longint'(ey));
      chk($sformatf("g%0d_err", k + 1), longint'(g_err[k]), 0);
      chk($sformatf("g%0d_lat", k + 1), longint'(glat[k]), longint'(exp_lat(k + 1, ir)));
    end
    @(negedge clk);
    g_out_ready = 1'b1;
    @(posedge clk);
    #1 g_out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] ry;
    logic       re;
    int         rl;
    logic [9:0] ra, rb, rm;

    in_valid = 0; reuse_mb = 0; out_ready = 0; a = 0; b = 0; m = 0;
    g_in_valid = 0; g_reuse = 0; g_out_ready = 0; g_a = 0; g_b = 0; g_m = 0;

    vecs[0] = '{8'd200, 8'd150, 8'd251, 1'b1, 8'd131, 1'b0, 8};
    vecs[1] = '{8'd7,   8'd150, 8'd251, 1'b1, 8'd46,  1'b0, 4};
    vecs[2] = '{8'd5,   8'd3,   8'd0,   1'b0, 8'd0,   1'b1, 1};
    vecs[3] = '{8'd251, 8'd10,  8'd251, 1'b0, 8'd0,   1'b1, 1};
    vecs[4] = '{8'd10,  8'd251, 8'd251, 1'b1, 8'd0,   1'b1, 1};
    vecs[5] = '{8'd100, 8'd150, 8'd251, 1'b1, 8'd191, 1'b0, 4};
    vecs[6] = '{8'd254, 8'd254, 8'd255, 1'b0, 8'd1,   1'b0, 8};
    vecs[7] = '{8'd2,   8'd254, 8'd255, 1'b1, 8'd253, 1'b0, 4};
    vecs[8] = '{8'd0,   8'd200, 8'd251, 1'b0, 8'd0,   1'b0, 8};
    vecs[9] = '{8'd0,   8'd0,   8'd1,   1'b0, 8'd0,   1'b0, 8};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_y", longint'(y), 0);
    chk("rst_err", longint'(err), 0);
    chk("rst_busy", longint'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].reuse, ry, re, rl);
      chk($sformatf("v%0d_y", i), longint'(ry), longint'(vecs[i].ey));
      chk($sformatf("v%0d_err", i), longint'(re), longint'(vecs[i].eerr));
      chk($sformatf("v%0d_lat", i), longint'(rl), longint'(vecs[i].elat));
      take8();
    end

    // Backpressure: result held, in_ready low, extra requests ignored
    op8(8'd3, 8'd150, 8'd251, 1'b0, ry, re, rl);
    chk("bp_y", longint'(ry), 199);
    chk("bp_lat", longint'(rl), 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 8'(i + 1);
      @(posedge clk);
      #1;
      chk("bp_out_valid", longint'(out_valid), 1);
      chk("bp_y_hold", longint'(y), 199);
      chk("bp_err_hold", longint'(err), 0);
      chk("bp_in_ready", longint'(in_ready), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    take8();
    repeat (2) @(posedge clk);
    #1 chk("bp_no_hidden_accept", longint'(busy), 0);

    // Reset mid-RUN, then reuse request must rebuild tables
    @(negedge clk);
    a = 8'd7; b = 8'd150; m = 8'd251; reuse_mb = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", longint'(in_ready), 1);
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_y", longint'(y), 0);
    chk("mid_rst_err", longint'(err), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    op8(8'd7, 8'd150, 8'd251, 1'b1, ry, re, rl);
    chk("post_rst_y", longint'(ry), 46);
    chk("post_rst_err", longint'(re), 0);
    chk("post_rst_lat", longint'(rl), 8);
    take8();

    // 10-bit instances: directed corner, then random triples with periodic reuse
    opg(10'd1020, 10'd1020, 10'd1021, 1'b0);
    opg(10'd5, 10'd1020, 10'd1021, 1'b1);
    ra = 0; rb = 0; rm = 1;
    for (int i = 0; i < 1000; i++) begin
      if (i % 2 == 0) begin
        rm = 10'($urandom_range(1, 1023));
        rb = 10'($urandom_range(0, int'(rm) - 1));
      end
      ra = 10'($urandom_range(0, int'(rm) - 1));
      opg(ra, rb, rm, (i % 2 == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
